// File: rtl/imem_loadable.sv
// Instruction memory with a streaming load port and a pipelined fetch port.
// A load burst blocks fetch acceptance; stages already in flight drain normally.
module imem_loadable #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int OUT_REG = 0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_stall,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W:0]   rem, rem_d;
  logic              beat;
  logic              accepted;

  logic [DATA_W-1:0] mem [DEPTH];

  // Load FSM state, write pointer and remaining-word count
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      rem   <= rem_d;
    end
  end

  // Next state, pointer/count update and load-port outputs
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    rem_d    = rem;
    beat     = 1'b0;
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          rem_d   = ld_len;
          state_d = (ld_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        beat     = ld_valid;
        if (ld_valid) begin
          ptr_d = ptr + 1'b1;
          rem_d = rem - 1'b1;
          if (rem == (ADDR_W+1)'(1)) state_d = DONE;
        end
      end
      DONE: begin
        ld_done = 1'b1;
        ld_busy = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory write port; the array is left unreset so contents survive rsta
  always_ff @(posedge clka) begin
    if (beat) mem[ptr] <= ld_data;
  end

  assign accepted = f_req & ~f_stall & ~ld_busy;

  if (OUT_REG == 0) begin : g_lat1
    // Single read stage; data only updates on an accepted request
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        f_valid <= 1'b0;
        f_data  <= '0;
      end else if (!f_stall) begin
        f_valid <= accepted;
        if (accepted) f_data <= mem[f_addr];
      end
    end
  end else begin : g_lat2
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    // Read stage plus output stage, both frozen by f_stall
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        f_valid  <= 1'b0;
        f_data   <= '0;
      end else if (!f_stall) begin
        s1_valid <= accepted;
        if (accepted) s1_data <= mem[f_addr];
        f_valid <= s1_valid;
        if (s1_valid) f_data <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable; drives one OUT_REG=0 and one OUT_REG=1
// instance from the same stimulus and checks each against hand-derived values.
module tb_imem_loadable;

  logic        clka = 1'b0;
  logic        rsta;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_stall;
  logic        ld_start;
  logic [9:0]  ld_base;
  logic [10:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;

  logic        v0, v1;
  logic [31:0] d0, d1;
  logic        ldr0, ldb0, ldd0;
  logic        ldr1, ldb1, ldd1;

  int checks = 0;
  int errors = 0;

  logic [31:0] a [4] = '{32'h0000_00A0, 32'h0000_00A1,
                         32'h0000_00A2, 32'h0000_00A3};
  logic [31:0] b0 = 32'h0000_00B0;
  logic [31:0] b1 = 32'h0000_00B1;
  logic [31:0] c0 = 32'h0000_00C0;
  logic [31:0] c1 = 32'h0000_00C1;

  always #5 clka = ~clka;

  imem_loadable #(.DATA_W(32), .ADDR_W(10), .OUT_REG(0)) u0 (
    .clka(clka), .rsta(rsta),
    .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall),
    .f_valid(v0), .f_data(d0),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ldr0), .ld_busy(ldb0), .ld_done(ldd0)
  );

  imem_loadable #(.DATA_W(32), .ADDR_W(10), .OUT_REG(1)) u1 (
    .clka(clka), .rsta(rsta),
    .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall),
    .f_valid(v1), .f_data(d1),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ldr1), .ld_busy(ldb1), .ld_done(ldd1)
  );

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset;
    rsta = 1'b1;
    f_req = 0; f_addr = '0; f_stall = 0;
    ld_start = 0; ld_base = '0; ld_len = '0;
    ld_valid = 0; ld_data = '0;
    step;
    step;
    if (v0 !== 1'b0) begin errors++; $display("FAIL rst_v0: got %b exp 0", v0); end checks++;
    if (d0 !== 32'd0) begin errors++; $display("FAIL rst_d0: got %h exp 0", d0); end checks++;
    if (v1 !== 1'b0) begin errors++; $display("FAIL rst_v1: got %b exp 0", v1); end checks++;
    if (d1 !== 32'd0) begin errors++; $display("FAIL rst_d1: got %h exp 0", d1); end checks++;
    if ({ldr0, ldb0, ldd0} !== 3'b000) begin errors++; $display("FAIL rst_ld0: got %b exp 000", {ldr0, ldb0, ldd0}); end checks++;
    if ({ldr1, ldb1, ldd1} !== 3'b000) begin errors++; $display("FAIL rst_ld1: got %b exp 000", {ldr1, ldb1, ldd1}); end checks++;
    rsta = 1'b0;
    step;
  endtask

  task automatic test_load;
    logic [5:0] pat;
    int k;
    pat = 6'b101101;
    k = 0;
    ld_base = 10'h3FE; ld_len = 11'd4; ld_start = 1;
    step;
    ld_start = 0;
    if (ldb0 !== 1'b1) begin errors++; $display("FAIL load_busy: got %b exp 1", ldb0); end checks++;
    if (ldr0 !== 1'b1) begin errors++; $display("FAIL load_ready: got %b exp 1", ldr0); end checks++;
    for (int i = 0; i < 6; i++) begin
      ld_valid = pat[i];
      ld_data = pat[i] ? a[k] : 32'hDEAD_BEEF;
      step;
      if (pat[i]) k++;
      if (i < 5) begin
        if (ldd0 !== 1'b0) begin errors++; $display("FAIL load_early_done: got %b exp 0 beat %0d", ldd0, i); end checks++;
        if (ldr0 !== 1'b1) begin errors++; $display("FAIL load_ready_mid: got %b exp 1 beat %0d", ldr0, i); end checks++;
      end
    end
    ld_valid = 0;
    if (ldd0 !== 1'b1) begin errors++; $display("FAIL load_done: got %b exp 1", ldd0); end checks++;
    if (ldr0 !== 1'b0) begin errors++; $display("FAIL done_ready: got %b exp 0", ldr0); end checks++;
    if (ldb0 !== 1'b1) begin errors++; $display("FAIL done_busy: got %b exp 1", ldb0); end checks++;
    step;
    if (ldd0 !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b exp 0", ldd0); end checks++;
    if (ldb0 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", ldb0); end checks++;
  endtask

  task automatic test_latency;
    f_addr = 10'h3FF; f_req = 1;
    step;
    f_req = 0;
    if (v0 !== 1'b1) begin errors++; $display("FAIL lat1_v0: got %b exp 1", v0); end checks++;
    if (d0 !== a[1]) begin errors++; $display("FAIL lat1_d0: got %h exp %h", d0, a[1]); end checks++;
    if (v1 !== 1'b0) begin errors++; $display("FAIL lat1_v1: got %b exp 0", v1); end checks++;
    step;
    if (v0 !== 1'b0) begin errors++; $display("FAIL lat2_v0: got %b exp 0", v0); end checks++;
    if (d0 !== a[1]) begin errors++; $display("FAIL lat2_d0_hold: got %h exp %h", d0, a[1]); end checks++;
    if (v1 !== 1'b1) begin errors++; $display("FAIL lat2_v1: got %b exp 1", v1); end checks++;
    if (d1 !== a[1]) begin errors++; $display("FAIL lat2_d1: got %h exp %h", d1, a[1]); end checks++;
    step;
    if (v1 !== 1'b0) begin errors++; $display("FAIL lat3_v1: got %b exp 0", v1); end checks++;
    if (d1 !== a[1]) begin errors++; $display("FAIL lat3_d1_hold: got %h exp %h", d1, a[1]); end checks++;
  endtask

  task automatic test_back_to_back;
    f_addr = 10'h000; f_req = 1;
    step;
    f_stall = 1; f_addr = 10'h001;
    for (int i = 0; i < 3; i++) begin
      step;
      if (v0 !== 1'b1) begin errors++; $display("FAIL stall_v0: got %b exp 1 cyc %0d", v0, i); end checks++;
      if (d0 !== a[2]) begin errors++; $display("FAIL stall_d0: got %h exp %h cyc %0d", d0, a[2], i); end checks++;
      if (v1 !== 1'b0) begin errors++; $display("FAIL stall_v1: got %b exp 0 cyc %0d", v1, i); end checks++;
    end
    f_stall = 0;
    step;
    f_addr = 10'h002;
    if (d0 !== a[3]) begin errors++; $display("FAIL b2b_d0_1: got %h exp %h", d0, a[3]); end checks++;
    if (v1 !== 1'b1) begin errors++; $display("FAIL b2b_v1_0: got %b exp 1", v1); end checks++;
    if (d1 !== a[2]) begin errors++; $display("FAIL b2b_d1_0: got %h exp %h", d1, a[2]); end checks++;
    step;
    f_req = 0;
    if (v0 !== 1'b1) begin errors++; $display("FAIL b2b_v0_2: got %b exp 1", v0); end checks++;
    if (d1 !== a[3]) begin errors++; $display("FAIL b2b_d1_1: got %h exp %h", d1, a[3]); end checks++;
    step;
    if (v0 !== 1'b0) begin errors++; $display("FAIL b2b_v0_end: got %b exp 0", v0); end checks++;
    if (v1 !== 1'b1) begin errors++; $display("FAIL b2b_v1_2: got %b exp 1", v1); end checks++;
    step;
    if (v1 !== 1'b0) begin errors++; $display("FAIL b2b_v1_end: got %b exp 0", v1); end checks++;
  endtask

  task automatic test_zero_len;
    ld_base = 10'h3FE; ld_len = 11'd0; ld_start = 1;
    ld_valid = 1; ld_data = 32'h0000_BAD0;
    step;
    ld_start = 0;
    if (ldd0 !== 1'b1) begin errors++; $display("FAIL zl_done: got %b exp 1", ldd0); end checks++;
    if (ldr0 !== 1'b0) begin errors++; $display("FAIL zl_ready: got %b exp 0", ldr0); end checks++;
    step;
    ld_valid = 0;
    if (ldd0 !== 1'b0) begin errors++; $display("FAIL zl_pulse: got %b exp 0", ldd0); end checks++;
    if (ldb0 !== 1'b0) begin errors++; $display("FAIL zl_busy: got %b exp 0", ldb0); end checks++;
    ld_base = 10'h010; ld_len = 11'd2; ld_start = 1;
    step;
    ld_base = 10'h020; ld_len = 11'd5;
    ld_valid = 1; ld_data = b0;
    step;
    ld_data = b1;
    step;
    ld_start = 0; ld_valid = 0;
    if (ldd0 !== 1'b1) begin errors++; $display("FAIL restart_ignored: got %b exp 1", ldd0); end checks++;
    step;
    f_addr = 10'h3FE; f_req = 1;
    step;
    f_addr = 10'h010;
    if (d0 !== a[0]) begin errors++; $display("FAIL zl_nowrite: got %h exp %h", d0, a[0]); end checks++;
    step;
    f_addr = 10'h011;
    if (d0 !== b0) begin errors++; $display("FAIL ld2_w0: got %h exp %h", d0, b0); end checks++;
    step;
    f_req = 0;
    if (d0 !== b1) begin errors++; $display("FAIL ld2_w1: got %h exp %h", d0, b1); end checks++;
    step;
  endtask

  task automatic test_load_reset;
    ld_base = 10'h100; ld_len = 11'd4; ld_start = 1;
    f_req = 1; f_addr = 10'h010;
    step;
    ld_start = 0;
    if (v0 !== 1'b1) begin errors++; $display("FAIL preload_v0: got %b exp 1", v0); end checks++;
    if (d0 !== b0) begin errors++; $display("FAIL preload_d0: got %h exp %h", d0, b0); end checks++;
    ld_valid = 1; ld_data = c0;
    step;
    if (v0 !== 1'b0) begin errors++; $display("FAIL busy_block0: got %b exp 0", v0); end checks++;
    ld_data = c1;
    step;
    if (v0 !== 1'b0) begin errors++; $display("FAIL busy_block1: got %b exp 0", v0); end checks++;
    if (d0 !== b0) begin errors++; $display("FAIL busy_d0_hold: got %h exp %h", d0, b0); end checks++;
    ld_valid = 0; f_req = 0;
    #3;
    rsta = 1;
    #1;
    if (ldb0 !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b exp 0", ldb0); end checks++;
    if (ldr0 !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b exp 0", ldr0); end checks++;
    if (d0 !== 32'd0) begin errors++; $display("FAIL arst_d0: got %h exp 0", d0); end checks++;
    if (d1 !== 32'd0) begin errors++; $display("FAIL arst_d1: got %h exp 0", d1); end checks++;
    step;
    if (ldd0 !== 1'b0) begin errors++; $display("FAIL arst_nodone0: got %b exp 0", ldd0); end checks++;
    rsta = 0;
    step;
    if (ldd0 !== 1'b0) begin errors++; $display("FAIL arst_nodone1: got %b exp 0", ldd0); end checks++;
    if (ldb0 !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b exp 0", ldb0); end checks++;
    f_req = 1; f_addr = 10'h100;
    step;
    f_addr = 10'h101;
    if (d0 !== c0) begin errors++; $display("FAIL kept_w0: got %h exp %h", d0, c0); end checks++;
    step;
    f_addr = 10'h010;
    if (d0 !== c1) begin errors++; $display("FAIL kept_w1: got %h exp %h", d0, c1); end checks++;
    step;
    f_req = 0;
    if (d0 !== b0) begin errors++; $display("FAIL survive_rst: got %h exp %h", d0, b0); end checks++;
    step;
  endtask

  initial begin
    test_reset;
    test_load;
    test_latency;
    test_back_to_back;
    test_zero_len;
    test_load_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
